// File: rtl/srsw_fifo_pkg.sv
// Shared sizing helpers and the default skid entry type for srsw_fifo_ctrl.
package srsw_fifo_pkg;

  // Total capacity: every memory slot plus the two skid registers.
  function automatic int fifo_cap(input int addr_width);
    return (1 << addr_width) + 2;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction

  localparam int SKID_DEF_W = 32;
  typedef logic [SKID_DEF_W-1:0] skid_entry_t;

endpackage

// File: rtl/srsw_skid2.sv
// Two-entry register FIFO; e0 is always the head. The caller never pushes when full
// and never pops when empty.
module srsw_skid2
  import srsw_fifo_pkg::*;
#(
  parameter type entry_t = skid_entry_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] occ
);

  entry_t e0, e1;

  assign head = e0;

  always_ff @(posedge clock) begin
    if (reset) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word becomes the tail.
          if (occ == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/srsw_fifo_ctrl.sv
// FIFO controller for a 1-cycle-latency SRSW memory with a 2-entry output skid.
// Define SRSW_FIFO_BYPASS_EN to let pushes into an idle queue skip the memory.
module srsw_fifo_ctrl
  import srsw_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [count_width(ADDR_WIDTH)-1:0] count,
  output logic                               mem_wen,
  output logic [ADDR_WIDTH-1:0]              mem_waddr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic                               mem_ren,
  output logic [ADDR_WIDTH-1:0]              mem_raddr,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

  localparam int            CW  = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] CAP = CW'(fifo_cap(ADDR_WIDTH));

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   mem_occ;
  logic                  inflight;
  logic [1:0]            skid_occ;
  logic [2:0]            skid_load;
  logic                  push, pop, bypass, mem_push, rd_issue, skid_push;
  word_t                 skid_data;

  assign count     = CW'(mem_occ) + CW'(inflight) + CW'(skid_occ);
  assign in_ready  = !reset && (count != CAP);
  assign out_valid = (skid_occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef SRSW_FIFO_BYPASS_EN
  assign bypass = push && (mem_occ == '0) && !inflight && (skid_occ != 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign mem_push  = push && !bypass;
  assign skid_push = inflight || bypass;
  assign skid_data = inflight ? mem_rdata : in_data;

  // Reserve skid space for the returning word; the slot freed by this cycle's
  // pop counts, which is what lets a streaming consumer take one word per cycle.
  assign skid_load = {1'b0, skid_occ} + {2'b00, inflight};
  assign rd_issue  = !reset && (mem_occ != '0) && (skid_load < (pop ? 3'd3 : 3'd2));

  assign mem_wen   = mem_push;
  assign mem_waddr = wptr;
  assign mem_wdata = in_data;
  assign mem_ren   = rd_issue;
  assign mem_raddr = rptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_occ  <= '0;
      inflight <= 1'b0;
    end else begin
      if (mem_push) wptr <= wptr + ADDR_WIDTH'(1);
      if (rd_issue) rptr <= rptr + ADDR_WIDTH'(1);
      inflight <= rd_issue;
      mem_occ  <= mem_occ + {{ADDR_WIDTH{1'b0}}, mem_push} - {{ADDR_WIDTH{1'b0}}, rd_issue};
    end
  end

  srsw_skid2 #(
    .entry_t(word_t)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .push     (skid_push),
    .push_data(skid_data),
    .pop      (pop),
    .head     (out_data),
    .occ      (skid_occ)
  );

endmodule

// File: tb/tb_srsw_fifo_ctrl.sv
// Directed and randomised checks for srsw_fifo_ctrl against a registered-read memory model.
module tb_srsw_fifo_ctrl;

`ifdef SRSW_FIFO_BYPASS_EN
  localparam int LAT = 1, STEADY = 1;
  localparam logic EXP_WEN = 1'b0;
`else
  localparam int LAT = 3, STEADY = 3;
  localparam logic EXP_WEN = 1'b1;
`endif

  logic        clock = 1'b0, run_mode = 1'b1, gate_en = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_data = '0, out_data, mem_wdata, mem_rdata;
  logic [3:0]  count;
  logic        mem_wen, mem_ren;
  logic [1:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_model [0:3];
  int          checks = 0, errors = 0;

  srsw_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // Glitch-free gated clock: it may only stop while low.
  always #5 if (run_mode || clock) clock = ~clock;

  always begin
    #7;
    run_mode = gate_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(posedge clock) begin
    if (mem_wen) mem_model[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem_model[mem_raddr];
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_mem_wen: got %b want 0", mem_wen); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL rst_mem_ren: got %b want 0", mem_ren); end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_release_count: got %0d want 0", count); end
  endtask

  // Push A0..A3 back-to-back with the consumer stalled.
  task automatic test_fill();
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      in_valid = (c < 4); in_data = 32'hA0 + c; out_ready = 1'b0;
      #1;
      checks++;
      if (count !== 4'((c < 4) ? c : 4)) begin
        errors++; $display("FAIL fill_count c=%0d: got %0d want %0d", c, count, (c < 4) ? c : 4);
      end
      checks++;
      if (out_valid !== (c >= LAT)) begin
        errors++; $display("FAIL fill_out_valid c=%0d: got %b want %b", c, out_valid, (c >= LAT));
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready c=%0d: got %b want 1", c, in_ready); end
      if (c >= LAT) begin
        checks++; if (out_data !== 32'hA0) begin errors++; $display("FAIL fill_head c=%0d: got %h want a0", c, out_data); end
      end
    end
    in_valid = 1'b0;
  endtask

  // Fill to capacity, hold a refused 0xFF, then drain in order.
  task automatic test_full();
    logic ff_acc;
    int   idx;
    logic [31:0] exp_d;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = 32'hA4 + c; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_push_ready c=%0d: got %b want 1", c, in_ready); end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = 32'hFF; out_ready = 1'b0;
      #1;
      checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_count c=%0d: got %0d want 6", c, count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready c=%0d: got %b want 0", c, in_ready); end
    end
    ff_acc = 1'b0; idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 7; cyc++) begin
      @(negedge clock);
      in_valid = !ff_acc; in_data = 32'hFF; out_ready = 1'b1;
      #1;
      if (cyc == 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_push: in_ready got %b want 0", in_ready); end
      end
      if (cyc < 6) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_rate cyc=%0d: out_valid got %b want 1", cyc, out_valid); end
      end
      if (out_valid) begin
        exp_d = (idx < 6) ? 32'hA0 + idx : 32'hFF;
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL drain_data idx=%0d: got %h want %h", idx, out_data, exp_d); end
        idx++;
      end
      if (in_valid && in_ready) ff_acc = 1'b1;
    end
    checks++; if (idx != 7) begin errors++; $display("FAIL drain_timeout: got %0d words want 7", idx); end
    checks++; if (ff_acc !== 1'b1) begin errors++; $display("FAIL ff_accept: got %b want 1", ff_acc); end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_empty_count: got %0d want 0", count); end
  endtask

  task automatic test_stream();
    int sent, rcv;
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = 32'h100 + sent; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d: got %b want 1", cyc, in_ready); end
      if (cyc >= 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid cyc=%0d: got %b want 1", cyc, out_valid); end
        checks++; if (count !== 4'(STEADY)) begin errors++; $display("FAIL stream_count cyc=%0d: got %0d want %0d", cyc, count, STEADY); end
      end
      if (out_valid) begin
        checks++; if (out_data !== 32'h100 + rcv) begin errors++; $display("FAIL stream_data %0d: got %h want %h", rcv, out_data, 32'h100 + rcv); end
        rcv++;
      end
      if (in_ready) sent++;
    end
    for (int k = 0; k < 20 && rcv < sent; k++) begin
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++; if (out_data !== 32'h100 + rcv) begin errors++; $display("FAIL stream_tail %0d: got %h want %h", rcv, out_data, 32'h100 + rcv); end
        rcv++;
      end
    end
    checks++; if (rcv != 20) begin errors++; $display("FAIL stream_total: got %0d want 20", rcv); end
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL stream_empty_count: got %0d want 0", count); end
  endtask

  // Twelve isolated push/pop pairs wrap both pointers three times.
  task automatic test_wrap();
    logic [31:0] d;
    logic        got;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      d = $urandom;
      @(negedge clock);
      in_valid = 1'b1; in_data = d; out_ready = 1'b0;
      #1;
      checks++; if (mem_wen !== EXP_WEN) begin errors++; $display("FAIL wrap_wen %0d: got %b want %b", i, mem_wen, EXP_WEN); end
`ifndef SRSW_FIFO_BYPASS_EN
      checks++; if (mem_waddr !== 2'(i)) begin errors++; $display("FAIL wrap_waddr %0d: got %0d want %0d", i, mem_waddr, i % 4); end
`endif
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        if (out_valid) begin
          got = 1'b1;
          checks++; if (out_data !== d) begin errors++; $display("FAIL wrap_data %0d: got %h want %h", i, out_data, d); end
        end
      end
      if (!got) begin checks++; errors++; $display("FAIL wrap_timeout %0d: got no word want %h", i, d); end
    end
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    logic got;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = 32'hC0 + c; out_ready = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    out_ready = 1'b1;
    #1;
    checks++; if (mem_ren !== 1'b1) begin errors++; $display("FAIL inflight_issue: mem_ren got %b want 1", mem_ren); end
    checks++; if (out_data !== 32'hC0) begin errors++; $display("FAIL inflight_head: got %h want c0", out_data); end
    @(negedge clock);
    out_ready = 1'b0; reset = 1'b1;
    #1;
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL inflight_rst_ren: got %b want 0", mem_ren); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_stale_valid c=%0d: got %b want 0", c, out_valid); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL inflight_count c=%0d: got %0d want 0", c, count); end
      @(negedge clock);
    end
    in_valid = 1'b1; in_data = 32'hD0;
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        checks++; if (out_data !== 32'hD0) begin errors++; $display("FAIL inflight_next: got %h want d0", out_data); end
      end
      @(negedge clock);
    end
    if (!got) begin checks++; errors++; $display("FAIL inflight_next_timeout: got none want d0"); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    longint      t_end;
    int          cyc;
    q = {}; cyc = 0;
    gate_en = 1'b1;
    t_end = $time + 5000;
    while ($time < t_end && cyc < 2000) begin
      @(negedge clock);
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d: got %0d want %0d", cyc, count, q.size()); end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_underflow cyc=%0d: got %h want nothing", cyc, out_data);
        end else begin
          if (out_data !== q[0]) begin errors++; $display("FAIL rnd_data cyc=%0d: got %h want %h", cyc, out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      cyc++;
    end
    gate_en = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_drain: got %h want %h", out_data, q[0]); end
        void'(q.pop_front());
      end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout: %0d words left want 0", q.size()); end
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rnd_final_count: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_stream();
    test_wrap();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
